// File: rtl/sram_port_arbiter_if.sv
// SRAM-like split-handshake bus bundle: N request channels sharing one return data bus.
// The master drives the request fields; the slave drives the accepts and read data.
interface sram_port_arbiter_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [N-1:0]          req;
  logic [N-1:0]          wr;
  logic [2*N-1:0]        size;
  logic [N*DATA_W/8-1:0] wstrb;
  logic [N*ADDR_W-1:0]   addr;
  logic [N*DATA_W-1:0]   wdata;
  logic [N-1:0]          addr_ok;
  logic [N-1:0]          data_ok;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// N-channel SRAM-like arbiter onto one slave port; in-order completions steered back via an ID FIFO.
// Define ARB_ROUND_ROBIN_EN for round-robin grant; otherwise the lowest requesting index wins.
module sram_port_arbiter #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_port_arbiter_if.slave    m,
  sram_port_arbiter_if.master   s,
  output logic                  protocol_err
);
  localparam int unsigned PW  = $clog2(OUTSTANDING);
  localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SW  = DATA_W / 8;

  typedef logic [IDW-1:0] ch_t;
  typedef enum logic {ST_OPEN, ST_LOCKED} lock_st_t;

  ch_t           r_id [OUTSTANDING];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  lock_st_t      r_lock_st;
  ch_t           r_lock_ch;
  logic          r_perr;

  ch_t           w_pick;
  logic          w_pick_any;
  ch_t           w_gnt;
  logic          w_any;
  logic          w_full;
  logic          w_sreq;
  logic          w_push;
  logic          w_pop;

`ifdef ARB_ROUND_ROBIN_EN
  ch_t r_rr_ptr;

  always_comb begin
    int unsigned idx;
    w_pick     = r_rr_ptr;
    w_pick_any = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(r_rr_ptr) + k) % NUM_CH;
      if (!w_pick_any && m.req[ch_t'(idx)]) begin
        w_pick_any = 1'b1;
        w_pick     = ch_t'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_gnt == ch_t'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
    end
  end
`else
  always_comb begin
    w_pick     = '0;
    w_pick_any = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!w_pick_any && m.req[ch_t'(k)]) begin
        w_pick_any = 1'b1;
        w_pick     = ch_t'(k);
      end
    end
  end
`endif

  // A stalled grant stays put; if its master withdraws, s_req drops and the lock clears next edge.
  assign w_gnt  = (r_lock_st == ST_LOCKED) ? r_lock_ch : w_pick;
  assign w_any  = (r_lock_st == ST_LOCKED) ? m.req[r_lock_ch] : w_pick_any;
  assign w_full = (r_count == (PW+1)'(OUTSTANDING));
  assign w_sreq = w_any & ~w_full & resetn;
  assign w_push = w_sreq & s.addr_ok[0];
  assign w_pop  = s.data_ok[0] & (r_count != '0);

  assign s.req[0] = w_sreq;
  assign s.wr[0]  = m.wr[w_gnt];
  assign s.size   = m.size[2*w_gnt +: 2];
  assign s.wstrb  = m.wstrb[w_gnt*SW +: SW];
  assign s.addr   = m.addr[w_gnt*ADDR_W +: ADDR_W];
  assign s.wdata  = m.wdata[w_gnt*DATA_W +: DATA_W];

  assign m.addr_ok = w_push ? (NUM_CH'(1) << w_gnt) : '0;
  assign m.data_ok = w_pop ? (NUM_CH'(1) << r_id[r_rptr]) : '0;
  assign m.rdata   = s.rdata;

  assign protocol_err = r_perr;

  always_ff @(posedge clk) begin
    if (w_push) r_id[r_wptr] <= w_gnt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_lock_st <= ST_OPEN;
      r_lock_ch <= '0;
      r_perr    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_sreq && !s.addr_ok[0]) begin
        r_lock_st <= ST_LOCKED;
        r_lock_ch <= w_gnt;
      end else begin
        r_lock_st <= ST_OPEN;
      end
      if (s.data_ok[0] && (r_count == '0)) r_perr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus pushes expected handshakes, a negedge monitor pops and checks.
module tb_sram_port_arbiter;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OUTSTANDING = 4;

  localparam logic [31:0] WDATA0 = 32'hDEAD_0000;
  localparam logic [31:0] WDATA1 = 32'h1111_2222;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [1:0] G1 = 2'b10;
`else
  localparam logic [1:0] G1 = 2'b01;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic protocol_err;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.N(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();
  sram_port_arbiter_if #(.N(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  sram_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTSTANDING(OUTSTANDING)
  ) dut (
    .clk(clk), .resetn(resetn), .m(m_if), .s(s_if), .protocol_err(protocol_err)
  );

  typedef struct { logic [1:0] oh; logic [31:0] addr; } aexp_t;
  typedef struct { logic [1:0] oh; logic [31:0] data; } dexp_t;
  aexp_t aq[$];
  dexp_t dq[$];
  aexp_t ae;
  dexp_t de;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every address or data handshake the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (m_if.addr_ok !== 2'b00) begin
      if (aq.size() == 0) begin
        chk("aok_unexpected", 64'(m_if.addr_ok), 64'd0);
      end else begin
        ae = aq.pop_front();
        chk("aok_ch",    64'(m_if.addr_ok), 64'(ae.oh));
        chk("aok_addr",  64'(s_if.addr),    64'(ae.addr));
        chk("aok_wr",    64'(s_if.wr),      (ae.oh == 2'b01) ? 64'd1 : 64'd0);
        chk("aok_size",  64'(s_if.size),    (ae.oh == 2'b01) ? 64'd2 : 64'd1);
        chk("aok_wstrb", 64'(s_if.wstrb),   (ae.oh == 2'b01) ? 64'hF : 64'h3);
        chk("aok_wdata", 64'(s_if.wdata),   (ae.oh == 2'b01) ? 64'(WDATA0) : 64'(WDATA1));
      end
    end
    if (m_if.data_ok !== 2'b00) begin
      if (dq.size() == 0) begin
        chk("dok_unexpected", 64'(m_if.data_ok), 64'd0);
      end else begin
        de = dq.pop_front();
        chk("dok_ch",    64'(m_if.data_ok), 64'(de.oh));
        chk("dok_rdata", 64'(m_if.rdata),   64'(de.data));
      end
    end
  end

  task automatic cyc(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                     input logic saok, input logic sdok, input logic [31:0] rd,
                     input logic exp_sreq, input logic [1:0] exp_aok, input logic [1:0] exp_dok,
                     input string tag);
    aexp_t ea;
    dexp_t ed;
    @(posedge clk);
    #1;
    m_if.req        = req;
    m_if.addr       = {a1, a0};
    s_if.addr_ok[0] = saok;
    s_if.data_ok[0] = sdok;
    s_if.rdata      = rd;
    if (exp_aok != 2'b00) begin
      ea.oh = exp_aok;
      ea.addr = (exp_aok == 2'b01) ? a0 : a1;
      aq.push_back(ea);
    end
    if (exp_dok != 2'b00) begin
      ed.oh = exp_dok;
      ed.data = rd;
      dq.push_back(ed);
    end
    @(negedge clk);
    chk({tag, "_sreq"}, 64'(s_if.req), 64'(exp_sreq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_if.req   = '0;
    m_if.wr    = 2'b01;
    m_if.size  = {2'd1, 2'd2};
    m_if.wstrb = {4'h3, 4'hF};
    m_if.addr  = '0;
    m_if.wdata = {WDATA1, WDATA0};
    s_if.addr_ok = '0;
    s_if.data_ok = '0;
    s_if.rdata   = '0;
    resetn = 1'b0;

    // Reset with every input asserted: outputs must stay quiet.
    #2;
    m_if.req = 2'b11;
    s_if.addr_ok = 1'b1;
    s_if.data_ok = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sreq", 64'(s_if.req),      64'd0);
    chk("rst_aok",  64'(m_if.addr_ok),  64'd0);
    chk("rst_dok",  64'(m_if.data_ok),  64'd0);
    chk("rst_perr", 64'(protocol_err),  64'd0);
    m_if.req = 2'b00;
    s_if.addr_ok = 1'b0;
    s_if.data_ok = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;

    // Single read on ch1
    cyc(2'b10, 32'h0, 32'hBFC0_0000, 1'b1, 1'b0, 32'h0,         1'b1, 2'b10, 2'b00, "rd1_c0");
    cyc(2'b00, 32'h0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, "rd1_c1");
    cyc(2'b00, 32'h0, 32'h0,         1'b0, 1'b1, 32'h3C1D_0000, 1'b0, 2'b00, 2'b10, "rd1_c2");

    // Contention with overlapping completions
    cyc(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, "ct0");
    cyc(2'b11, 32'h104, 32'h204, 1'b1, 1'b1, 32'hAAAA_0001, 1'b1, G1,    2'b01, "ct1");
    cyc(2'b11, 32'h108, 32'h208, 1'b1, 1'b1, 32'hBBBB_0002, 1'b1, 2'b01, G1,    "ct2");
    cyc(2'b00, 32'h0,   32'h0,   1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 2'b00, 2'b01, "ct3");

    // Lock: ch1 stalled three cycles while ch0 also requests
    cyc(2'b10, 32'h300, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, "lk0");
    chk("lk0_addr", 64'(s_if.addr), 64'h400);
    cyc(2'b11, 32'h300, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, "lk1");
    chk("lk1_addr", 64'(s_if.addr), 64'h400);
    cyc(2'b11, 32'h300, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, "lk2");
    chk("lk2_addr", 64'(s_if.addr), 64'h400);
    cyc(2'b11, 32'h300, 32'h400, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00, "lk3");
    cyc(2'b11, 32'h300, 32'h400, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, "lk4");
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDDDD_0004, 1'b0, 2'b00, 2'b10, "lk5");
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hEEEE_0005, 1'b0, 2'b00, 2'b01, "lk6");

    // Stray completion with empty FIFO
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hF00D_0006, 1'b0, 2'b00, 2'b00, "st0");
    chk("st0_dok",  64'(m_if.data_ok), 64'd0);
    chk("st0_perr", 64'(protocol_err), 64'd0);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, "st1");
    chk("st1_perr", 64'(protocol_err), 64'd1);

    // Fill FIFO, block, pop while full, resume
    cyc(2'b01, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, "fl0");
    cyc(2'b01, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, "fl1");
    cyc(2'b01, 32'h18, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, "fl2");
    cyc(2'b01, 32'h1C, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, "fl3");
    cyc(2'b01, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, "fl4");
    cyc(2'b01, 32'h20, 32'h0, 1'b1, 1'b1, 32'h5555_0010, 1'b0, 2'b00, 2'b01, "fl5");
    cyc(2'b01, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, "fl6");
    chk("fl6_perr", 64'(protocol_err), 64'd1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_0014, 1'b0, 2'b00, 2'b01, "fl7");
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_0018, 1'b0, 2'b00, 2'b01, "fl8");

    // Asynchronous reset mid-cycle with two transactions outstanding
    @(posedge clk);
    #1;
    m_if.req = 2'b01;
    m_if.addr = {32'h0, 32'h30};
    s_if.addr_ok = 1'b1;
    s_if.data_ok = 1'b0;
    #1;
    chk("mr_pre_sreq", 64'(s_if.req),     64'd1);
    chk("mr_pre_perr", 64'(protocol_err), 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("mr_sreq", 64'(s_if.req),     64'd0);
    chk("mr_aok",  64'(m_if.addr_ok), 64'd0);
    chk("mr_perr", 64'(protocol_err), 64'd0);
    @(posedge clk);
    #1;
    m_if.req = 2'b00;
    s_if.addr_ok = 1'b0;
    resetn = 1'b1;

    // Post-reset completion must be stray: FIFO was emptied
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7777_0000, 1'b0, 2'b00, 2'b00, "pr0");
    chk("pr0_dok", 64'(m_if.data_ok), 64'd0);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, "pr1");
    chk("pr1_perr", 64'(protocol_err), 64'd1);

    @(negedge clk);
    chk("aq_left", 64'(aq.size()), 64'd0);
    chk("dq_left", 64'(dq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
